data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 106 ++++++++++
 tb/tb_data_sram_resp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// ---------------------------------------------------------------------------
// data_sram_resp
//   Word-organised data SRAM with byte-lane writes. Read responses come back
//   through a fixed-latency pipeline. Requests whose address lies above the
//   decoded range are flagged with data_sram_err. For reads this flag appears
//   together with a zero response word. For writes it appears as a one-cycle
//   err pulse, and the memory is left unchanged.
//
//   Parameters
//     ADDR_W  byte-address bits decoded; depth = 2^(ADDR_W-2) words
//     RD_LAT  read latency in cycles (1..4)
//
//   Ports
//     clk              clock, rising edge
//     resetn           asynchronous active-low reset
//     data_sram_en     request strobe, one request per cycle
//     data_sram_we     byte-lane write enables, 4'b0000 = read
//     data_sram_addr   byte address, bits [1:0] ignored
//     data_sram_wdata  store data
//     data_sram_rdata  read response word, held while rvalid=0
//     data_sram_rvalid response valid
//     data_sram_err    out-of-range flag, aligned with the response slot
//     busy             at least one read is in flight
// ---------------------------------------------------------------------------
module data_sram_resp #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_err,
    output logic        busy
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic              out_of_range;
    logic              rd_req;
    logic              wr_req;
    logic [31:0]       rd_word;

    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_e;
    logic [31:0]       pipe_w [RD_LAT];

    assign word_idx     = data_sram_addr[ADDR_W-1:2];
    assign out_of_range = (data_sram_addr >> ADDR_W) != 32'd0;
    assign rd_req       = data_sram_en && (data_sram_we == 4'b0000);
    assign wr_req       = data_sram_en && (data_sram_we != 4'b0000) && !out_of_range;

    // The read word is captured at the sampling edge. A write sampled
    // later therefore cannot alter a response that is already in flight.
    assign rd_word = out_of_range ? 32'd0 : mem[word_idx];

    // The array itself is never reset. A request presented while reset is
    // low is dropped, because resetn is checked synchronously here.
    always_ff @(posedge clk) begin
        if (resetn && wr_req) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // A word moves forward only together with a valid read. An idle slot
    // therefore never overwrites the word in the next stage, and the last
    // stage keeps the most recently returned word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_w[i] <= 32'd0;
            end
        end else begin
            pipe_v[0] <= rd_req;
            pipe_e[0] <= data_sram_en && out_of_range;
            if (rd_req) begin
                pipe_w[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                if (pipe_v[i-1]) begin
                    pipe_w[i] <= pipe_w[i-1];
                end
            end
        end
    end

    assign data_sram_rdata  = pipe_w[RD_LAT-1];
    assign data_sram_rvalid = pipe_v[RD_LAT-1];
    assign data_sram_err    = pipe_e[RD_LAT-1];
    assign busy             = |pipe_v;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

    localparam int NDUT = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic        err0, err1;
    logic        busy0, busy1;

    typedef struct {
        int          issue;
        logic        rd;
        logic        er;
        logic [31:0] data;
    } exp_t;

    exp_t        q [NDUT][$];
    logic [31:0] last [NDUT];
    int          lat [NDUT];
    int          cyc;
    int          vectors;
    int          miscompares;

    data_sram_resp #(.ADDR_W(16), .RD_LAT(LAT0)) u_lat1 (
        .clk(clk), .resetn(resetn),
        .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_rdata(rdata0), .data_sram_rvalid(rvalid0),
        .data_sram_err(err0), .busy(busy0)
    );

    data_sram_resp #(.ADDR_W(16), .RD_LAT(LAT1)) u_lat3 (
        .clk(clk), .resetn(resetn),
        .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_rdata(rdata1), .data_sram_rvalid(rvalid1),
        .data_sram_err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    logic        m_v, m_e, m_b, b_exp, due;
    logic [31:0] m_rd;
    exp_t        front;
    always @(negedge clk) begin
        if (resetn) begin
            for (int d = 0; d < NDUT; d++) begin
                m_v  = (d == 0) ? rvalid0 : rvalid1;
                m_e  = (d == 0) ? err0    : err1;
                m_b  = (d == 0) ? busy0   : busy1;
                m_rd = (d == 0) ? rdata0  : rdata1;
                b_exp = 1'b0;
                foreach (q[d][k]) begin
                    if (q[d][k].rd && q[d][k].issue <= cyc) b_exp = 1'b1;
                end
                check($sformatf("busy[lat%0d]", lat[d]), {31'd0, m_b}, {31'd0, b_exp});
                due = (q[d].size() > 0) && (q[d][0].issue + lat[d] - 1 == cyc);
                if (m_v || m_e) begin
                    if (!due) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp[lat%0d]: got rvalid=%b err=%b, expected none (cycle %0d)",
                                 lat[d], m_v, m_e, cyc);
                    end else begin
                        front = q[d].pop_front();
                        check($sformatf("rvalid[lat%0d]", lat[d]), {31'd0, m_v}, {31'd0, front.rd});
                        check($sformatf("err[lat%0d]", lat[d]), {31'd0, m_e}, {31'd0, front.er});
                        if (front.rd) begin
                            check($sformatf("rdata[lat%0d]", lat[d]), m_rd, front.data);
                            last[d] = front.data;
                        end else begin
                            check($sformatf("rdata_hold[lat%0d]", lat[d]), m_rd, last[d]);
                        end
                    end
                end else begin
                    if (due) begin
                        front = q[d].pop_front();
                        vectors++;
                        miscompares++;
                        $display("FAIL missing_resp[lat%0d]: got no response, expected rd=%b err=%b data=%h (cycle %0d)",
                                 lat[d], front.rd, front.er, front.data, cyc);
                    end
                    check($sformatf("rdata_hold[lat%0d]", lat[d]), m_rd, last[d]);
                end
            end
        end
    end

    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(negedge clk);
        en = 1'b1; we = w; addr = a; wdata = d;
        if (w == 4'b0000 || exp_err) begin
            e.issue = cyc + 1;
            e.rd    = (w == 4'b0000);
            e.er    = exp_err;
            e.data  = exp_data;
            for (int k = 0; k < NDUT; k++) q[k].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = 1'b0; we = 4'h0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata1"},  rdata0, 32'd0);
        check({tag, "_rvalid1"}, {31'd0, rvalid0}, 32'd0);
        check({tag, "_err1"},    {31'd0, err0}, 32'd0);
        check({tag, "_busy1"},   {31'd0, busy0}, 32'd0);
        check({tag, "_rdata3"},  rdata1, 32'd0);
        check({tag, "_rvalid3"}, {31'd0, rvalid1}, 32'd0);
        check({tag, "_err3"},    {31'd0, err1}, 32'd0);
        check({tag, "_busy3"},   {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        lat[0] = LAT0; lat[1] = LAT1;
        last[0] = 32'd0; last[1] = 32'd0;
        en = 1'b0; we = 4'h0; addr = 32'd0; wdata = 32'd0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // full write then read
        req(4'hF, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        req(4'h0, 32'h10, 32'h0, 32'h1122_3344, 1'b0);
        // byte lane 1 only
        req(4'b0010, 32'h10, 32'h0000_AB00, 32'h0, 1'b0);
        req(4'h0, 32'h10, 32'h0, 32'h1122_AB44, 1'b0);
        // back-to-back reads
        req(4'hF, 32'h0, 32'h0000_00A0, 32'h0, 1'b0);
        req(4'hF, 32'h4, 32'h0000_00A4, 32'h0, 1'b0);
        req(4'hF, 32'h8, 32'h0000_00A8, 32'h0, 1'b0);
        req(4'h0, 32'h0, 32'h0, 32'h0000_00A0, 1'b0);
        req(4'h0, 32'h4, 32'h0, 32'h0000_00A4, 1'b0);
        req(4'h0, 32'h8, 32'h0, 32'h0000_00A8, 1'b0);
        idle(4);
        // read followed by a write to the same word
        req(4'hF, 32'h20, 32'h5, 32'h0, 1'b0);
        idle(1);
        req(4'h0, 32'h20, 32'h0, 32'h5, 1'b0);
        req(4'hF, 32'h20, 32'h9, 32'h0, 1'b0);
        req(4'h0, 32'h20, 32'h0, 32'h9, 1'b0);
        idle(4);
        // out of range
        req(4'h0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        req(4'hF, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req(4'h0, 32'h0, 32'h0, 32'h0000_00A0, 1'b0);
        req(4'h0, 32'h10, 32'h0, 32'h1122_AB44, 1'b0);
        req(4'hF, 32'h8000_0004, 32'h0000_0077, 32'h0, 1'b1);
        idle(1);
        req(4'h0, 32'h4, 32'h0, 32'h0000_00A4, 1'b0);
        // lanes 3 and 0
        req(4'hF, 32'h24, 32'h0, 32'h0, 1'b0);
        req(4'b1000, 32'h24, 32'hCC00_0000, 32'h0, 1'b0);
        req(4'b0001, 32'h24, 32'h1234_565A, 32'h0, 1'b0);
        req(4'h0, 32'h24, 32'h0, 32'hCC00_005A, 1'b0);
        idle(5);

        // reset while a read is in flight
        req(4'h0, 32'h8, 32'h0, 32'h0000_00A8, 1'b0);
        idle(1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("midreset");
        for (int k = 0; k < NDUT; k++) begin
            q[k].delete();
            last[k] = 32'd0;
        end
        @(negedge clk); en = 1'b1; we = 4'hF; addr = 32'h4; wdata = 32'h0000_0BAD;
        @(negedge clk); en = 1'b1; we = 4'h0; addr = 32'h4;
        @(negedge clk); en = 1'b0; we = 4'h0;
        #1 check_reset_outputs("held_reset");
        @(negedge clk);
        resetn = 1'b1;
        idle(6);
        req(4'h0, 32'h4, 32'h0, 32'h0000_00A4, 1'b0);
        req(4'h0, 32'h8, 32'h0, 32'h0000_00A8, 1'b0);
        idle(6);

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("queue_empty[lat%0d]", lat[k]), q[k].size(), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
